// File: rtl/hdmi_link_ctrl_if.sv
// Decoder-side bundle for the HDMI link controller: per-channel
// alignment status in, per-channel phase-align FSM reset out.
interface hdmi_link_ctrl_if;
  logic [2:0] ch_vld;
  logic [2:0] ch_rdy;
  logic [2:0] ch_psalgnerr;
  logic [2:0] rst_fsm;

  modport master (
    input  ch_vld,
    input  ch_rdy,
    input  ch_psalgnerr,
    output rst_fsm
  );

  modport slave (
    output ch_vld,
    output ch_rdy,
    output ch_psalgnerr,
    input  rst_fsm
  );
endinterface

// File: rtl/hdmi_link_ctrl.sv
// HDMI RX link bring-up: reset, phase-align, bond, monitor, retry.
// Define LINK_STATS_EN to build the saturating link-drop counter.
module hdmi_link_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int TMO_W         = 20,
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_RETRY     = 7
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             locked,
  hdmi_link_ctrl_if.master lnk,
  output logic             link_up,
  output logic             link_fail,
  output logic [3:0]       retry_cnt,
  output logic [2:0]       state_out,
  output logic [7:0]       link_drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_ALIGN = 3'd2,
    S_BOND  = 3'd3,
    S_UP    = 3'd4,
    S_RETRY = 3'd5,
    S_FAIL  = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [7:0]       rst_cnt;
  logic [7:0]       rst_cnt_nx;
  logic [TMO_W-1:0] tmo;
  logic [TMO_W-1:0] tmo_nx;
  logic [TMO_W-1:0] tmo_inc;
  logic [7:0]       stb;
  logic [7:0]       stb_nx;
  logic [7:0]       stb_inc;
  logic [3:0]       rty_nx;
  logic [2:0]       rst_fsm_nx;
  logic             up_nx;
  logic             fail_nx;

  logic vld_all;
  logic rdy_all;
  logic err_any;
  logic tmo_hit;
  logic stb_hit;
  logic rst_done;
  logic in_win;
  logic win_nx;

  assign vld_all  = &lnk.ch_vld;
  assign rdy_all  = &lnk.ch_rdy;
  assign err_any  = |lnk.ch_psalgnerr;
  assign tmo_inc  = (&tmo) ? tmo : tmo + TMO_W'(1);
  assign tmo_hit  = &tmo_inc;
  assign stb_inc  = stb + 8'd1;
  assign stb_hit  = rdy_all && (stb_inc == 8'(STABLE_CYCLES));
  assign rst_done = (rst_cnt == 8'(RST_CYCLES - 1));

  // Timeout and not-valid exits are checked first so they win.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (locked) state_nx = S_RESET;
      end
      S_RESET: begin
        if (rst_done) state_nx = S_ALIGN;
      end
      S_ALIGN: begin
        if (tmo_hit)      state_nx = S_RETRY;
        else if (vld_all) state_nx = S_BOND;
      end
      S_BOND: begin
        if (tmo_hit || !vld_all) state_nx = S_RETRY;
        else if (stb_hit)        state_nx = S_UP;
      end
      S_UP: begin
        if (!vld_all || err_any) state_nx = S_RETRY;
      end
      S_RETRY: begin
        if (retry_cnt == 4'(MAX_RETRY)) state_nx = S_FAIL;
        else                            state_nx = S_RESET;
      end
      S_FAIL: begin
        state_nx = S_FAIL;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
    if (!locked) state_nx = S_IDLE;
  end

  assign in_win = (state == S_ALIGN) || (state == S_BOND);
  assign win_nx = (state_nx == S_ALIGN) || (state_nx == S_BOND);

  always_comb begin
    rst_cnt_nx = 8'd0;
    tmo_nx     = '0;
    stb_nx     = 8'd0;
    rty_nx     = retry_cnt;
    if (state == S_RESET && state_nx == S_RESET)
      rst_cnt_nx = rst_cnt + 8'd1;
    if (in_win && win_nx)
      tmo_nx = tmo_inc;
    if (state == S_BOND && state_nx == S_BOND && rdy_all)
      stb_nx = stb_inc;
    if (state_nx == S_IDLE || state_nx == S_UP)
      rty_nx = 4'd0;
    else if (state_nx == S_RETRY && retry_cnt != 4'hf)
      rty_nx = retry_cnt + 4'd1;
  end

  // Outputs are decoded from the next state so the flops line up with it.
  always_comb begin
    rst_fsm_nx = 3'b000;
    up_nx      = 1'b0;
    fail_nx    = 1'b0;
    unique case (1'b1)
      state_nx == S_IDLE,
      state_nx == S_RESET: rst_fsm_nx = 3'b111;
      state_nx == S_FAIL: begin
        rst_fsm_nx = 3'b111;
        fail_nx    = 1'b1;
      end
      state_nx == S_UP: up_nx = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      rst_cnt     <= 8'd0;
      tmo         <= '0;
      stb         <= 8'd0;
      retry_cnt   <= 4'd0;
      lnk.rst_fsm <= 3'b111;
      link_up     <= 1'b0;
      link_fail   <= 1'b0;
    end else begin
      state       <= state_nx;
      rst_cnt     <= rst_cnt_nx;
      tmo         <= tmo_nx;
      stb         <= stb_nx;
      retry_cnt   <= rty_nx;
      lnk.rst_fsm <= rst_fsm_nx;
      link_up     <= up_nx;
      link_fail   <= fail_nx;
    end
  end

  assign state_out = state;

`ifdef LINK_STATS_EN
  logic       drop;
  logic [7:0] drop_q;

  assign drop = (state == S_UP) && (state_nx == S_RETRY);

  always_ff @(posedge pclk) begin
    if (!rst_n)
      drop_q <= 8'd0;
    else if (drop && drop_q != 8'hff)
      drop_q <= drop_q + 8'd1;
  end

  assign link_drop_cnt = drop_q;
`else
  assign link_drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_hdmi_link_ctrl.sv
// Directed bench: bring-up, drops, bond glitch, timeout/fail,
// and mid-operation resets on default and short-timeout instances.
module tb_hdmi_link_ctrl;

`ifdef LINK_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       pclk;
  logic       rst_n;
  logic       locked;
  logic       locked_t;
  logic       link_up;
  logic       link_fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_out;
  logic [7:0] drop_cnt;
  logic       link_up_t;
  logic       link_fail_t;
  logic [3:0] retry_cnt_t;
  logic [2:0] state_out_t;
  logic [7:0] drop_cnt_t;

  int n_tests;
  int n_fail;

  hdmi_link_ctrl_if lnk ();
  hdmi_link_ctrl_if lnk_t ();

  hdmi_link_ctrl dut (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .locked        (locked),
    .lnk           (lnk),
    .link_up       (link_up),
    .link_fail     (link_fail),
    .retry_cnt     (retry_cnt),
    .state_out     (state_out),
    .link_drop_cnt (drop_cnt)
  );

  hdmi_link_ctrl #(.TMO_W(4)) dut_t (
    .pclk          (pclk),
    .rst_n         (rst_n),
    .locked        (locked_t),
    .lnk           (lnk_t),
    .link_up       (link_up_t),
    .link_fail     (link_fail_t),
    .retry_cnt     (retry_cnt_t),
    .state_out     (state_out_t),
    .link_drop_cnt (drop_cnt_t)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    int n;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    locked  = 1'b0;
    locked_t = 1'b0;
    lnk.ch_vld = 3'b000;
    lnk.ch_rdy = 3'b000;
    lnk.ch_psalgnerr = 3'b000;
    lnk_t.ch_vld = 3'b000;
    lnk_t.ch_rdy = 3'b000;
    lnk_t.ch_psalgnerr = 3'b000;
    tick();
    tick();
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_fsm", 32'(lnk.rst_fsm), 32'd7);
    check("rst_up", 32'(link_up), 32'd0);
    check("rst_fail", 32'(link_fail), 32'd0);
    check("rst_retry", 32'(retry_cnt), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // nominal bring-up
    rst_n  = 1'b1;
    locked = 1'b1;
    tick();
    check("nom_reset", 32'(state_out), 32'd1);
    n = 0;
    while (state_out == 3'd1 && lnk.rst_fsm == 3'b111 && n < 50) begin
      n++;
      tick();
    end
    check("nom_rst_len", 32'(n), 32'd4);
    check("nom_align", 32'(state_out), 32'd2);
    check("nom_rst_low", 32'(lnk.rst_fsm), 32'd0);
    repeat (10) tick();
    check("nom_wait", 32'(state_out), 32'd2);
    lnk.ch_vld = 3'b111;
    lnk.ch_rdy = 3'b111;
    tick();
    check("nom_bond", 32'(state_out), 32'd3);
    n = 0;
    while (!link_up && n < 100) begin
      tick();
      n++;
    end
    check("nom_bond_len", 32'(n), 32'd16);
    check("nom_up", 32'(state_out), 32'd4);
    check("nom_retry", 32'(retry_cnt), 32'd0);

    // single-cycle valid drop in UP
    lnk.ch_vld = 3'b101;
    tick();
    lnk.ch_vld = 3'b111;
    check("drop_state", 32'(state_out), 32'd5);
    check("drop_up", 32'(link_up), 32'd0);
    check("drop_retry", 32'(retry_cnt), 32'd1);
    check("drop_cnt1", 32'(drop_cnt), 32'(STATS));
    tick();
    check("drop_reset", 32'(state_out), 32'd1);
    n = 0;
    while (state_out == 3'd1 && lnk.rst_fsm == 3'b111 && n < 50) begin
      n++;
      tick();
    end
    check("drop_rst_len", 32'(n), 32'd4);
    check("drop_align", 32'(state_out), 32'd2);
    check("drop_retry_k", 32'(retry_cnt), 32'd1);

    // bonding glitch at stable count 10
    tick();
    check("gl_bond", 32'(state_out), 32'd3);
    repeat (10) tick();
    check("gl_pre", 32'(state_out), 32'd3);
    check("gl_pre_up", 32'(link_up), 32'd0);
    lnk.ch_rdy = 3'b011;
    tick();
    lnk.ch_rdy = 3'b111;
    check("gl_hold", 32'(state_out), 32'd3);
    n = 0;
    while (!link_up && n < 100) begin
      tick();
      n++;
    end
    check("gl_len", 32'(n), 32'd16);
    check("gl_retry_clr", 32'(retry_cnt), 32'd0);

    // phase-alignment error in UP
    lnk.ch_psalgnerr = 3'b010;
    tick();
    lnk.ch_psalgnerr = 3'b000;
    check("err_state", 32'(state_out), 32'd5);
    check("err_retry", 32'(retry_cnt), 32'd1);
    check("err_drop", 32'(drop_cnt), 32'(2 * STATS));
    tick();
    check("err_reset", 32'(state_out), 32'd1);

    // locked loss while in RESET
    locked = 1'b0;
    tick();
    check("lk_state", 32'(state_out), 32'd0);
    check("lk_fsm", 32'(lnk.rst_fsm), 32'd7);
    check("lk_up", 32'(link_up), 32'd0);
    check("lk_fail", 32'(link_fail), 32'd0);
    check("lk_retry", 32'(retry_cnt), 32'd0);
    check("lk_drop", 32'(drop_cnt), 32'(2 * STATS));

    // rst_n while in BOND
    locked = 1'b1;
    n = 0;
    while (state_out != 3'd3 && n < 50) begin
      tick();
      n++;
    end
    check("mr_bond", 32'(state_out), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mr_state", 32'(state_out), 32'd0);
    check("mr_fsm", 32'(lnk.rst_fsm), 32'd7);
    check("mr_up", 32'(link_up), 32'd0);
    check("mr_retry", 32'(retry_cnt), 32'd0);
    check("mr_drop", 32'(drop_cnt), 32'd0);

    // alignment timeout and retry exhaustion, TMO_W=4
    locked_t = 1'b1;
    tick();
    check("to_reset", 32'(state_out_t), 32'd1);
    n = 0;
    while (state_out_t != 3'd2 && n < 20) begin
      tick();
      n++;
    end
    n = 0;
    while (state_out_t == 3'd2 && n < 50) begin
      n++;
      tick();
    end
    check("to_len", 32'(n), 32'd15);
    check("to_retry_st", 32'(state_out_t), 32'd5);
    check("to_retry1", 32'(retry_cnt_t), 32'd1);
    n = 0;
    while (state_out_t != 3'd6 && n < 300) begin
      tick();
      n++;
    end
    check("fail_state", 32'(state_out_t), 32'd6);
    check("fail_flag", 32'(link_fail_t), 32'd1);
    check("fail_retry", 32'(retry_cnt_t), 32'd7);
    check("fail_fsm", 32'(lnk_t.rst_fsm), 32'd7);
    repeat (5) tick();
    check("fail_hold", 32'(state_out_t), 32'd6);
    locked_t = 1'b0;
    tick();
    check("fail_idle", 32'(state_out_t), 32'd0);
    check("fail_rclr", 32'(retry_cnt_t), 32'd0);
    check("fail_fclr", 32'(link_fail_t), 32'd0);
    check("fail_drop", 32'(drop_cnt_t), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
